cfg_stream_loader: RTL and testbench
====================================

Name: cfg_stream_loader

Overview:
- Configuration bitstream loader sitting directly upstream of the cell-block / CLB / switch-box programming chain.
- Accepts configuration words from a host over a valid/ready handshake and serialises them LSB-first onto prog_in with prog_en.
- Loads exactly CHAIN_LEN bits.
- Optional verify pass: the host re-sends the same stream, and the block compares the chain's returning prog_out bit-by-bit against the bit being sent. This needs no local bitstream memory.

Parameters:
- CHAIN_LEN, 20: total configuration bits in the chain. Must be ≥ 2.
- WORD_W, 8: host word width. Must be ≥ 2.
- CNT_W, 16: width of the mismatch counter.

Ports:
- prog_clk  in  1  single clock; the chain is also clocked by prog_clk.
- prog_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- verify  in  1  sampled with start; 1 = verify pass, 0 = load pass.
- word_data  in  WORD_W  host configuration word.
- word_valid  in  1  word_data valid.
- word_ready  out  1  block accepts word_data this cycle.
- prog_in  out  1  serial configuration bit to the chain.
- prog_en  out  1  chain shift enable.
- prog_out  in  1  bit returning from the far end of the chain.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- verify_fail  out  1  last verify pass saw ≥1 mismatch.
- mismatch_cnt  out  CNT_W  mismatches counted in the last verify pass; saturating.

Behaviour:
- Reset: async assert, sync-free deassert. State=IDLE; prog_in=0, prog_en=0, word_ready=0, busy=0, done=0, verify_fail=0, mismatch_cnt=0; all counters = 0.
- Reset mid-pass aborts immediately. The chain keeps its partial contents, and a fresh load is required.
- NWORDS = ceil(CHAIN_LEN/WORD_W). Bits of the final word beyond CHAIN_LEN are discarded and never shifted.
- FSM: IDLE -> RUN on start (latch verify; clear mismatch_cnt and verify_fail when verify=1) -> DRAIN when bit_cnt reaches CHAIN_LEN -> IDLE.
- start while busy is ignored.
- Data path: WORD_W-bit shifter sreg with a bits-remaining count wbits.
- word_ready = (state==RUN) && words_taken<NWORDS && (wbits==0 || (wbits==1 && a bit is issued this cycle)). This gives gapless streaming.
- Handshake: a word transfers on the rising edge where word_valid && word_ready. It loads sreg and sets wbits = min(WORD_W, remaining bits).
- Each cycle in RUN where wbits>0: register prog_in<=sreg[0], prog_en<=1, shift sreg right, decrement wbits, increment bit_cnt. Otherwise prog_en<=0, and the chain holds.
- Host stalls (word_valid low) simply insert prog_en=0 bubbles; no data is lost.
- Latency: the first bit appears on prog_in/prog_en one cycle after the first accepted word.
- Ordering: the first bit sent ends up farthest from prog_in, so it is the first bit to emerge at prog_out.
- Verify compare: on every edge where the registered prog_en==1 during a verify pass, compare prog_out with the registered prog_in. The compare happens before the chain drops that bit.
- Mismatch handling: on mismatch, mismatch_cnt increments, saturating at all-ones, and verify_fail<=1.
- A verify pass leaves the chain contents unchanged, provided the host re-sends an identical stream.
- DRAIN: one cycle, so that the final prog_en beat completes its compare. It then drops prog_en to 0, pulses done=1 for one cycle, and returns to IDLE.
- busy=1 from the cycle after start until done inclusive.
- verify_fail and mismatch_cnt hold until the next verify start. A load pass does not alter them.
- word_valid in IDLE or DRAIN is ignored; word_ready=0 in those states.

Decomposition:
- Shared package cfg_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - chain-length constants per tile: CB_CHAIN_LEN=20, plus the CLB and SB lengths as defined there;
  - a function ceil_div used for NWORDS.
- One natural sub-module, cfg_word_serializer: sreg plus wbits, word_ready generation, and bit issue.
- The FSM, bit_cnt and verify logic stay in the top module.

Test Plan:
- Load: CHAIN_LEN=20, WORD_W=8, bench chain model is a 20-bit shift register. start, verify=0; words 0xA5, 0x3C, 0x0F sent back-to-back -> exactly 20 prog_en beats with no gaps, first prog_in=1 one cycle after the first accept; chain holds bits {0xF(4 bits),0x3C,0xA5}, and the upper nibble of 0x0F is never shifted; done pulses once; busy falls with done.
- Verify pass, clean: after the load above, start with verify=1 and the same three words -> verify_fail=0, mismatch_cnt=0, chain contents unchanged.
- Verify pass, corrupted: bench flips chain bit 5 before verify -> mismatch_cnt=1, verify_fail=1 at done.
- Host stall: word_valid held low 3 cycles between word 1 and word 2 -> prog_en low exactly 3 cycles, total prog_en beats still 20, final chain contents identical to the no-stall case.
- Reset mid-pass: assert prog_rst_n=0 after 9 bits -> all outputs 0 immediately; a subsequent full load produces correct contents and a single done pulse.
- Ignored events: start pulsed during RUN, and word_valid asserted in IDLE -> no extra words accepted, bit count unaffected, done pulses exactly once.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package cfg_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } cfg_state_t;

   // Programming-chain lengths per tile type
   localparam int CB_CHAIN_LEN  = 20;
   localparam int CLB_CHAIN_LEN = 36;
   localparam int SB_CHAIN_LEN  = 48;

   // Integer ceiling division, used to size the host word count
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word-to-bit serializer: holds one host word, issues it LSB-first onto the
// programming chain and asks for the next word early enough to avoid bubbles.
module cfg_word_serializer
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = CB_CHAIN_LEN,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              run,
   input  logic              clear,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              issue,
   output logic              prog_in,
   output logic              prog_en
);

   localparam int NWORDS    = ceil_div(CHAIN_LEN, WORD_W);
   localparam int WB_W      = $clog2(WORD_W + 1);
   localparam int WT_W      = $clog2(NWORDS + 1);
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;

   localparam logic [WT_W-1:0] NWORDS_V       = WT_W'(NWORDS);
   localparam logic [WT_W-1:0] LAST_IDX       = WT_W'(NWORDS - 1);
   localparam logic [WB_W-1:0] FULL_WORD_BITS = WB_W'(WORD_W);
   localparam logic [WB_W-1:0] LAST_WORD_BITS = WB_W'(LAST_BITS);

   logic [WORD_W-1:0] sreg;
   logic [WB_W-1:0]   wbits;
   logic [WT_W-1:0]   words_taken;
   logic [WB_W-1:0]   load_bits;
   logic              accept;

   // Only the final word is truncated; its excess high bits are never shifted
   assign load_bits = (words_taken == LAST_IDX) ? LAST_WORD_BITS : FULL_WORD_BITS;

   // A bit goes out whenever the shifter still holds unsent bits
   assign issue = run && (wbits != '0);

   // Request the next word while the last bit of the current one is leaving
   assign word_ready = run && (words_taken < NWORDS_V) &&
                       ((wbits == '0) || ((wbits == WB_W'(1)) && issue));

   assign accept = word_valid && word_ready;

   // Shifter, bit count, word count and the registered chain drive
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         sreg        <= '0;
         wbits       <= '0;
         words_taken <= '0;
         prog_in     <= 1'b0;
         prog_en     <= 1'b0;
      end else begin
         prog_en <= issue;
         if (issue) begin
            prog_in <= sreg[0];
         end
         if (clear) begin
            words_taken <= '0;
            wbits       <= '0;
         end else if (accept) begin
            sreg        <= word_data;
            wbits       <= load_bits;
            words_taken <= words_taken + WT_W'(1);
         end else if (issue) begin
            sreg  <= {1'b0, sreg[WORD_W-1:1]};
            wbits <= wbits - WB_W'(1);
         end
      end
   end

endmodule

// File: rtl/cfg_stream_loader.sv
// Configuration bitstream loader: streams host words into the programming
// chain and, on a verify pass, checks the returning bits without local storage.
module cfg_stream_loader
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = CB_CHAIN_LEN,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              verify,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              prog_in,
   output logic              prog_en,
   input  logic              prog_out,
   output logic              busy,
   output logic              done,
   output logic              verify_fail,
   output logic [CNT_W-1:0]  mismatch_cnt
);

   localparam int BC_W = $clog2(CHAIN_LEN + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CHAIN_LEN - 1);

   cfg_state_t      state;
   cfg_state_t      state_nxt;
   logic [BC_W-1:0] bit_cnt;
   logic            is_verify;
   logic            issue;
   logic            start_ok;

   // The done cycle still counts as busy, so a start there is ignored too
   assign start_ok = (state == IDLE) && start && !done;
   assign busy     = (state != IDLE) || done;

   cfg_word_serializer #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W)
   ) u_ser (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .run        (state == RUN),
      .clear      (start_ok),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .issue      (issue),
      .prog_in    (prog_in),
      .prog_en    (prog_en)
   );

   // State register
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave RUN on the edge that issues the last chain bit
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = RUN;
         RUN:     if (issue && (bit_cnt == LAST_BIT)) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pass bookkeeping: bit count, latched pass type and the done pulse
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         bit_cnt   <= '0;
         is_verify <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= (state == DRAIN);
         if (start_ok) begin
            bit_cnt   <= '0;
            is_verify <= verify;
         end else if (issue) begin
            bit_cnt <= bit_cnt + BC_W'(1);
         end
      end
   end

   // Verify compare: the chain's outgoing bit must equal the bit going in
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         verify_fail  <= 1'b0;
         mismatch_cnt <= '0;
      end else if (start_ok && verify) begin
         verify_fail  <= 1'b0;
         mismatch_cnt <= '0;
      end else if (is_verify && prog_en && (state != IDLE) && (prog_out != prog_in)) begin
         verify_fail <= 1'b1;
         if (mismatch_cnt != '1) begin
            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader with a behavioural chain model.
module tb_cfg_stream_loader;

   localparam int CHAIN_LEN = 20;
   localparam int WORD_W    = 8;
   localparam int CNT_W     = 16;
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

   logic              prog_clk = 1'b0;
   logic              prog_rst_n = 1'b0;
   logic              start = 1'b0;
   logic              verify = 1'b0;
   logic [WORD_W-1:0] word_data = '0;
   logic              word_valid = 1'b0;
   logic              word_ready;
   logic              prog_in;
   logic              prog_en;
   logic              prog_out;
   logic              busy;
   logic              done;
   logic              verify_fail;
   logic [CNT_W-1:0]  mismatch_cnt;

   logic [CHAIN_LEN-1:0] chain = '0;
   logic [CHAIN_LEN-1:0] exp_bits = '0;
   logic [CHAIN_LEN-1:0] flip_mask = '0;
   logic                 flip_en = 1'b0;
   logic [WORD_W-1:0]    host_words [NWORDS];

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int tot_beats = 0;
   int tot_acc = 0;
   int tot_done = 0;
   int tot_gaps = 0;
   int zero_run = 0;
   int base_beats = 0;
   int beat_idx;
   int first_beat_cyc = -1;
   int first_acc_cyc = -1;
   int model_mis = 0;
   bit model_fail = 1'b0;
   bit abort = 1'b0;

   cfg_stream_loader #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W),
      .CNT_W     (CNT_W)
   ) dut (
      .prog_clk     (prog_clk),
      .prog_rst_n   (prog_rst_n),
      .start        (start),
      .verify       (verify),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .prog_in      (prog_in),
      .prog_en      (prog_en),
      .prog_out     (prog_out),
      .busy         (busy),
      .done         (done),
      .verify_fail  (verify_fail),
      .mismatch_cnt (mismatch_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   // Programming chain: chain[0] is the far end; not cleared by the loader reset
   assign prog_out = chain[0];
   always @(posedge prog_clk) begin
      if (prog_en) chain <= {prog_in, chain[CHAIN_LEN-1:1]};
      else if (flip_en) chain <= chain ^ flip_mask;
   end

   always @(posedge prog_clk) cyc <= cyc + 1;

   assign beat_idx = tot_beats - base_beats;

   // Bus monitor: per-beat bit check, beat/gap/accept/done bookkeeping
   always @(negedge prog_clk) begin
      if (word_valid && word_ready) tot_acc <= tot_acc + 1;
      if (done) tot_done <= tot_done + 1;
      if (prog_en) begin
         if (beat_idx < CHAIN_LEN) checkOutput($sformatf("bit%0d", beat_idx), 32'(prog_in), 32'(exp_bits[beat_idx]));
         else checkOutput("beat_overrun", 32'(beat_idx), 32'(CHAIN_LEN - 1));
         if (beat_idx == 0) first_beat_cyc <= cyc;
         else tot_gaps <= tot_gaps + zero_run;
         zero_run  <= 0;
         tot_beats <= tot_beats + 1;
      end else begin
         zero_run <= zero_run + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Host side: present each word when ready, optionally skipping ready cycles first
   task automatic driveWords(input int stall_idx, input int stall_len);
      for (int w = 0; w < NWORDS; w++) begin
         int skip;
         int guard;
         bit sent;
         skip = (w == stall_idx) ? stall_len : 0;
         guard = 0;
         sent = 1'b0;
         while (!sent && !abort && guard < 300) begin
            @(negedge prog_clk);
            guard++;
            if (!abort && word_ready) begin
               if (skip > 0) skip--;
               else begin
                  word_data = host_words[w];
                  word_valid = 1'b1;
                  if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
                  @(posedge prog_clk);
                  #1;
                  word_valid = 1'b0;
                  sent = 1'b1;
               end
            end
         end
         if (abort) break;
         if (!sent) begin
            checkOutput($sformatf("accept_timeout_w%0d", w), 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic corruptChain(input logic [CHAIN_LEN-1:0] mask);
      @(negedge prog_clk);
      flip_mask = mask;
      flip_en = 1'b1;
      @(negedge prog_clk);
      flip_en = 1'b0;
   endtask

   // One pass: expected stream built from host_words, then the pass is run and scored
   task automatic applyStimulus(input bit vfy, input int stall_idx, input int stall_len,
                                input bit extra_evt, input int abort_at);
      logic [CHAIN_LEN-1:0] old_chain;
      logic [CHAIN_LEN-1:0] exp_chain;
      int exp_mis;
      int b_acc;
      int b_done;
      int b_gaps;
      int guard;
      bit got_done;
      for (int i = 0; i < CHAIN_LEN; i++) exp_bits[i] = host_words[i / WORD_W][i % WORD_W];
      old_chain = chain;
      exp_mis = 0;
      for (int i = 0; i < CHAIN_LEN; i++) if (old_chain[i] !== exp_bits[i]) exp_mis++;
      abort = 1'b0;
      if (extra_evt) begin
         word_data = WORD_W'($urandom);
         word_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            checkOutput("idle_ready", 32'(word_ready), 32'd0);
         end
      end
      @(negedge prog_clk);
      base_beats = tot_beats;
      b_acc = tot_acc;
      b_done = tot_done;
      b_gaps = tot_gaps;
      first_acc_cyc = -1;
      start = 1'b1;
      verify = vfy;
      word_valid = 1'b0;
      @(negedge prog_clk);
      start = 1'b0;
      fork
         driveWords(stall_idx, stall_len);
         begin
            if (extra_evt) begin
               repeat (4) @(negedge prog_clk);
               start = 1'b1;
               verify = ~vfy;
               @(negedge prog_clk);
               start = 1'b0;
               verify = vfy;
            end
         end
         begin
            if (abort_at > 0) begin
               guard = 0;
               while (tot_beats - base_beats < abort_at && guard < 500) begin
                  @(negedge prog_clk);
                  #1;
                  guard++;
               end
               checkOutput("abort_point", 32'(tot_beats - base_beats), 32'(abort_at));
               @(posedge prog_clk);
               #1;
               prog_rst_n = 1'b0;
               abort = 1'b1;
               #1;
               checkOutput("rst_prog_en", 32'(prog_en), 32'd0);
               checkOutput("rst_prog_in", 32'(prog_in), 32'd0);
               checkOutput("rst_word_ready", 32'(word_ready), 32'd0);
               checkOutput("rst_busy", 32'(busy), 32'd0);
               checkOutput("rst_done", 32'(done), 32'd0);
               checkOutput("rst_verify_fail", 32'(verify_fail), 32'd0);
               checkOutput("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
               repeat (3) @(negedge prog_clk);
               prog_rst_n = 1'b1;
            end
         end
      join
      if (abort_at > 0) begin
         for (int i = 0; i < CHAIN_LEN; i++)
            exp_chain[i] = (i >= CHAIN_LEN - abort_at) ? exp_bits[i - (CHAIN_LEN - abort_at)]
                                                       : old_chain[i + abort_at];
         checkOutput("abort_chain", 32'(chain), 32'(exp_chain));
         model_mis = 0;
         model_fail = 1'b0;
         return;
      end
      got_done = 1'b0;
      guard = 0;
      while (!got_done && guard < 400) begin
         @(negedge prog_clk);
         guard++;
         if (done) got_done = 1'b1;
      end
      checkOutput("done_seen", 32'(got_done), 32'd1);
      checkOutput("busy_at_done", 32'(busy), 32'd1);
      @(negedge prog_clk);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
      checkOutput("done_width", 32'(done), 32'd0);
      repeat (2) @(negedge prog_clk);
      #1;
      checkOutput("done_count", 32'(tot_done - b_done), 32'd1);
      checkOutput("beat_count", 32'(tot_beats - base_beats), 32'(CHAIN_LEN));
      checkOutput("accept_count", 32'(tot_acc - b_acc), 32'(NWORDS));
      checkOutput("gap_count", 32'(tot_gaps - b_gaps), 32'((stall_idx >= 1) ? stall_len : 0));
      checkOutput("first_bit_latency", 32'(first_beat_cyc), 32'(first_acc_cyc + 1));
      checkOutput("chain_contents", 32'(chain), 32'(exp_bits));
      if (vfy) begin
         model_mis = (exp_mis > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : exp_mis;
         model_fail = (exp_mis > 0);
      end
      checkOutput("mismatch_cnt", 32'(mismatch_cnt), 32'(model_mis));
      checkOutput("verify_fail", 32'(verify_fail), 32'(model_fail));
   endtask

   // Global time limit so the bench can never hang
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [CHAIN_LEN-1:0] mask;
      int nflip;
      #2;
      checkOutput("reset_prog_en", 32'(prog_en), 32'd0);
      checkOutput("reset_prog_in", 32'(prog_in), 32'd0);
      checkOutput("reset_word_ready", 32'(word_ready), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_verify_fail", 32'(verify_fail), 32'd0);
      checkOutput("reset_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
      repeat (2) @(negedge prog_clk);
      prog_rst_n = 1'b1;
      repeat (2) @(negedge prog_clk);

      $display("[TB] directed load");
      host_words[0] = 8'hA5;
      host_words[1] = 8'h3C;
      host_words[2] = 8'h0F;
      applyStimulus(1'b0, -1, 0, 1'b0, 0);
      checkOutput("load_chain_const", 32'(chain), 32'h000F3CA5);

      $display("[TB] clean verify");
      applyStimulus(1'b1, -1, 0, 1'b0, 0);
      checkOutput("clean_mismatch", 32'(mismatch_cnt), 32'd0);

      $display("[TB] corrupted verify");
      corruptChain(CHAIN_LEN'(1) << 5);
      applyStimulus(1'b1, -1, 0, 1'b0, 0);
      checkOutput("corrupt_mismatch", 32'(mismatch_cnt), 32'd1);
      checkOutput("corrupt_fail", 32'(verify_fail), 32'd1);

      $display("[TB] host stall");
      applyStimulus(1'b0, 1, 3, 1'b0, 0);
      checkOutput("stall_chain_const", 32'(chain), 32'h000F3CA5);

      $display("[TB] reset mid-pass");
      for (int w = 0; w < NWORDS; w++) host_words[w] = WORD_W'($urandom);
      applyStimulus(1'b0, -1, 0, 1'b0, 9);
      repeat (2) @(negedge prog_clk);
      applyStimulus(1'b0, -1, 0, 1'b0, 0);

      $display("[TB] ignored start and idle valid");
      applyStimulus(1'b0, -1, 0, 1'b1, 0);

      $display("[TB] randomized passes");
      for (int it = 0; it < 10; it++) begin
         for (int w = 0; w < NWORDS; w++) host_words[w] = WORD_W'($urandom);
         applyStimulus(1'b0, $urandom_range(0, NWORDS - 1), $urandom_range(0, 4), 1'b0, 0);
         mask = '0;
         nflip = $urandom_range(0, 3);
         for (int k = 0; k < nflip; k++) mask = mask ^ (CHAIN_LEN'(1) << $urandom_range(0, CHAIN_LEN - 1));
         if (mask != '0) corruptChain(mask);
         applyStimulus(1'b1, $urandom_range(0, NWORDS - 1), $urandom_range(0, 4), 1'(it % 3 == 0), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
